// File: rtl/video_pkg.sv
// video_pkg
// Shared definitions for the video processing path.
//   - RGB565 field positions
//   - clog2w(): minimum register width for a count (never narrower than 1)
//   - track_state_t: skin box tracker FSM states
//   - default RGB565 colours
package video_pkg;

  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ACCUM     = 2'd1,
    LATCH     = 2'd2
  } track_state_t;

  function automatic int clog2w(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/box_overlay_draw.sv
// box_overlay_draw
// Paints the border of a latched rectangle onto a pixel stream with one
// cycle of latency and delays the sync signals to stay aligned.
// Ports:
//   clk, rst_n                pixel clock, async active-low reset
//   vsync, href, clken        input syncs (delayed by 1 cycle to post_*)
//   x_pos, y_pos              coordinate of the current pixel
//   box_valid, box_*          rectangle to draw (previous frame's result)
//   pix_data                  incoming RGB565 pixel
//   post_vsync/href/clken     delayed syncs
//   post_data                 output pixel, 0 while post_href is low
module box_overlay_draw
  import video_pkg::*;
#(
  parameter int          XW        = 10,
  parameter int          YW        = 9,
  parameter int          LINE_W    = 2,
  parameter logic [15:0] BOX_COLOR = COLOR_RED
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          href,
  input  logic          clken,
  input  logic [XW-1:0] x_pos,
  input  logic [YW-1:0] y_pos,
  input  logic          box_valid,
  input  logic [XW-1:0] box_x_min,
  input  logic [XW-1:0] box_x_max,
  input  logic [YW-1:0] box_y_min,
  input  logic [YW-1:0] box_y_max,
  input  logic [15:0]   pix_data,
  output logic          post_vsync,
  output logic          post_href,
  output logic          post_clken,
  output logic [15:0]   post_data
);

  // One extra bit so min + (LINE_W-1) and pos + (LINE_W-1) never wrap.
  localparam int XE = XW + 1;
  localparam int YE = YW + 1;
  localparam logic [XE-1:0] X_SPAN = XE'(LINE_W - 1);
  localparam logic [YE-1:0] Y_SPAN = YE'(LINE_W - 1);

  logic [XE-1:0] x_e, xmin_e, xmax_e;
  logic [YE-1:0] y_e, ymin_e, ymax_e;
  logic          in_rect, near_x, near_y, paint;

  assign x_e    = {1'b0, x_pos};
  assign xmin_e = {1'b0, box_x_min};
  assign xmax_e = {1'b0, box_x_max};
  assign y_e    = {1'b0, y_pos};
  assign ymin_e = {1'b0, box_y_min};
  assign ymax_e = {1'b0, box_y_max};

  assign in_rect = (x_e >= xmin_e) && (x_e <= xmax_e) &&
                   (y_e >= ymin_e) && (y_e <= ymax_e);

  // Border band lies inward from each edge; a degenerate box (min==max)
  // makes every inside pixel a border pixel.
  assign near_x = (x_e <= xmin_e + X_SPAN) || (x_e + X_SPAN >= xmax_e);
  assign near_y = (y_e <= ymin_e + Y_SPAN) || (y_e + Y_SPAN >= ymax_e);
  assign paint  = box_valid && in_rect && (near_x || near_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vsync <= 1'b0;
      post_href  <= 1'b0;
      post_clken <= 1'b0;
      post_data  <= '0;
    end else begin
      post_vsync <= vsync;
      post_href  <= href;
      post_clken <= clken;
      if (!href)
        post_data <= '0;
      else if (paint)
        post_data <= BOX_COLOR;
      else
        post_data <= pix_data;
    end
  end

endmodule

// File: rtl/skin_box_tracker.sv
// skin_box_tracker
// Tracks the bounding box and pixel count of the skin mask over each frame,
// latches the result at the next frame start and draws the latched box as
// a border on the outgoing video.
// Ports:
//   clk, rst_n                       pixel clock, async active-low reset
//   per_frame_vsync/href/clken       input frame, line and pixel strobes
//   per_img_mask, per_img_data       skin mask bit and aligned RGB565 pixel
//   post_frame_vsync/href/clken      strobes delayed by 1 cycle
//   post_img_data                    pixel with border overlaid
//   box_valid                        latched count reached MIN_PIX
//   box_x_min/x_max/y_min/y_max      latched bounds
//   box_count                        latched mask pixel count
//   frame_done                       1-cycle pulse when box_* update
module skin_box_tracker
  import video_pkg::*;
#(
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int          MIN_PIX   = 64,
  parameter logic [15:0] BOX_COLOR = COLOR_RED,
  parameter int          LINE_W    = 2,
  localparam int         XW        = clog2w(IMG_W),
  localparam int         YW        = clog2w(IMG_H),
  localparam int         CW        = clog2w(IMG_W * IMG_H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic          per_img_mask,
  input  logic [15:0]   per_img_data,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic [15:0]   post_img_data,
  output logic          box_valid,
  output logic [XW-1:0] box_x_min,
  output logic [XW-1:0] box_x_max,
  output logic [YW-1:0] box_y_min,
  output logic [YW-1:0] box_y_max,
  output logic [CW-1:0] box_count,
  output logic          frame_done
);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIX);

  logic          vs_d, href_d, vs_rise, href_fall;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          x_sat, y_sat;
  logic          pix_en, mask_hit;
  track_state_t  state;
  logic [XW-1:0] acc_x_min, acc_x_max;
  logic [YW-1:0] acc_y_min, acc_y_max;
  logic [CW-1:0] acc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d   <= 1'b0;
      href_d <= 1'b0;
    end else begin
      vs_d   <= per_frame_vsync;
      href_d <= per_frame_href;
    end
  end

  assign vs_rise   = per_frame_vsync & ~vs_d;
  assign href_fall = ~per_frame_href & href_d;
  assign pix_en    = per_frame_clken & per_frame_href;

  // x_sat / y_sat flag that the counter already sat on its last value when
  // another pixel or line arrived, i.e. the stream ran past the active area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      x_sat <= 1'b0;
      y_cnt <= '0;
      y_sat <= 1'b0;
    end else if (vs_rise) begin
      x_cnt <= '0;
      x_sat <= 1'b0;
      y_cnt <= '0;
      y_sat <= 1'b0;
    end else if (href_fall) begin
      x_cnt <= '0;
      x_sat <= 1'b0;
      if (y_cnt == Y_LAST)
        y_sat <= 1'b1;
      else
        y_cnt <= y_cnt + 1'b1;
    end else if (pix_en) begin
      if (x_cnt == X_LAST)
        x_sat <= 1'b1;
      else
        x_cnt <= x_cnt + 1'b1;
    end
  end

  assign mask_hit = pix_en & per_img_mask & ~per_frame_vsync & ~x_sat & ~y_sat;

  // vs_rise is checked before mask_hit so a pixel colliding with the frame
  // boundary is dropped. The accumulators are restored to their empty
  // values both when tracking starts and right after each latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SYNC;
      acc_x_min  <= X_LAST;
      acc_x_max  <= '0;
      acc_y_min  <= Y_LAST;
      acc_y_max  <= '0;
      acc_cnt    <= '0;
      box_valid  <= 1'b0;
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
      box_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_SYNC: begin
          if (vs_rise) begin
            acc_x_min <= X_LAST;
            acc_x_max <= '0;
            acc_y_min <= Y_LAST;
            acc_y_max <= '0;
            acc_cnt   <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (vs_rise) begin
            state <= LATCH;
          end else if (mask_hit) begin
            if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
            if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
            if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
            if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
            if (acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
          end
        end
        LATCH: begin
          box_x_min  <= acc_x_min;
          box_x_max  <= acc_x_max;
          box_y_min  <= acc_y_min;
          box_y_max  <= acc_y_max;
          box_count  <= acc_cnt;
          box_valid  <= (acc_cnt >= MIN_CNT);
          frame_done <= 1'b1;
          acc_x_min  <= X_LAST;
          acc_x_max  <= '0;
          acc_y_min  <= Y_LAST;
          acc_y_max  <= '0;
          acc_cnt    <= '0;
          state      <= ACCUM;
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end

  box_overlay_draw #(
    .XW        (XW),
    .YW        (YW),
    .LINE_W    (LINE_W),
    .BOX_COLOR (BOX_COLOR)
  ) u_overlay (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (per_frame_vsync),
    .href       (per_frame_href),
    .clken      (per_frame_clken),
    .x_pos      (x_cnt),
    .y_pos      (y_cnt),
    .box_valid  (box_valid),
    .box_x_min  (box_x_min),
    .box_x_max  (box_x_max),
    .box_y_min  (box_y_min),
    .box_y_max  (box_y_max),
    .pix_data   (per_img_data),
    .post_vsync (post_frame_vsync),
    .post_href  (post_frame_href),
    .post_clken (post_frame_clken),
    .post_data  (post_img_data)
  );

endmodule

// File: tb/tb_skin_box_tracker.sv
// tb_skin_box_tracker
// Drives whole frames (vsync blanking, lines with random pixel-enable gaps)
// and compares the tracker against a frame-level reference: the set of mask
// pixel coordinates seen in a frame defines the expected box, and each
// pixel's expected output follows from the previously latched box.
module tb_skin_box_tracker;

  localparam int          IMG_W     = 16;
  localparam int          IMG_H     = 8;
  localparam int          MIN_PIX   = 4;
  localparam int          LINE_W    = 1;
  localparam logic [15:0] BOX_COLOR = 16'hF800;
  localparam logic [15:0] GREEN     = 16'h07E0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic        per_img_mask = 1'b0;
  logic [15:0] per_img_data = 16'h0;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [15:0] post_img_data;
  logic        box_valid;
  logic [3:0]  box_x_min, box_x_max;
  logic [2:0]  box_y_min, box_y_max;
  logic [7:0]  box_count;
  logic        frame_done;

  skin_box_tracker #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .MIN_PIX   (MIN_PIX),
    .BOX_COLOR (BOX_COLOR),
    .LINE_W    (LINE_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_mask     (per_img_mask),
    .per_img_data     (per_img_data),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_data    (post_img_data),
    .box_valid        (box_valid),
    .box_x_min        (box_x_min),
    .box_x_max        (box_x_max),
    .box_y_min        (box_y_min),
    .box_y_max        (box_y_max),
    .box_count        (box_count),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit    armed;
  bit    mv;
  int    mxmin, mxmax, mymin, mymax;
  int    hit_x[$];
  int    hit_y[$];
  int    x_pos, y_pos;
  bit    chk_en;
  int    fd_cnt;
  logic  exp_vs, exp_hr, exp_ce;
  logic [15:0] exp_data;
  string exp_tag;
  logic [15:0] mask_row [IMG_H];

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic bit on_border(input int x, input int y);
    if (!mv) return 1'b0;
    if (x < mxmin || x > mxmax || y < mymin || y > mymax) return 1'b0;
    return (x - mxmin < LINE_W) || (mxmax - x < LINE_W) ||
           (y - mymin < LINE_W) || (mymax - y < LINE_W);
  endfunction

  // Called at a falling edge: drives one cycle of input, checks that the
  // outputs still show the previous cycle's expectation, then waits a cycle.
  task automatic apply_stimulus(input logic vs, input logic hr, input logic ce,
                                input logic mk, input logic [15:0] data);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_mask    = mk;
    per_img_data    = data;
    #1;
    if (chk_en) begin
      check_output({"vsync_dly ", exp_tag}, 32'(post_frame_vsync), 32'(exp_vs));
      check_output({"href_dly ", exp_tag},  32'(post_frame_href),  32'(exp_hr));
      check_output({"clken_dly ", exp_tag}, 32'(post_frame_clken), 32'(exp_ce));
      check_output({"data ", exp_tag},      32'(post_img_data),    32'(exp_data));
    end
    if (armed && !vs && hr && ce && mk) begin
      hit_x.push_back(x_pos);
      hit_y.push_back(y_pos);
    end
    exp_vs   = vs;
    exp_hr   = hr;
    exp_ce   = ce;
    exp_data = !hr ? 16'h0 : (on_border(x_pos, y_pos) ? BOX_COLOR : data);
    exp_tag  = $sformatf("pix(%0d,%0d)", x_pos, y_pos);
    if (hr && ce) x_pos++;
    @(negedge clk);
    fd_cnt += int'(frame_done);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " post_vsync"}, 32'(post_frame_vsync), 32'd0);
    check_output({tag, " post_href"},  32'(post_frame_href),  32'd0);
    check_output({tag, " post_clken"}, 32'(post_frame_clken), 32'd0);
    check_output({tag, " post_data"},  32'(post_img_data),    32'd0);
    check_output({tag, " box_valid"},  32'(box_valid),        32'd0);
    check_output({tag, " box_x_min"},  32'(box_x_min),        32'd0);
    check_output({tag, " box_x_max"},  32'(box_x_max),        32'd0);
    check_output({tag, " box_y_min"},  32'(box_y_min),        32'd0);
    check_output({tag, " box_y_max"},  32'(box_y_max),        32'd0);
    check_output({tag, " box_count"},  32'(box_count),        32'd0);
    check_output({tag, " frame_done"}, 32'(frame_done),       32'd0);
  endtask

  task automatic expect_latch();
    int xmin = IMG_W - 1;
    int xmax = 0;
    int ymin = IMG_H - 1;
    int ymax = 0;
    int cnt  = hit_x.size();
    foreach (hit_x[i]) begin
      if (hit_x[i] < xmin) xmin = hit_x[i];
      if (hit_x[i] > xmax) xmax = hit_x[i];
      if (hit_y[i] < ymin) ymin = hit_y[i];
      if (hit_y[i] > ymax) ymax = hit_y[i];
    end
    check_output("frame_done_cycles", 32'(fd_cnt), 32'd1);
    check_output("box_x_min", 32'(box_x_min), 32'(xmin));
    check_output("box_x_max", 32'(box_x_max), 32'(xmax));
    check_output("box_y_min", 32'(box_y_min), 32'(ymin));
    check_output("box_y_max", 32'(box_y_max), 32'(ymax));
    check_output("box_count", 32'(box_count), 32'(cnt));
    check_output("box_valid", 32'(box_valid), 32'(cnt >= MIN_PIX));
    mv    = (cnt >= MIN_PIX);
    mxmin = xmin;
    mxmax = xmax;
    mymin = ymin;
    mymax = ymax;
  endtask

  // Vertical blanking; with collide set, a qualified mask pixel arrives in
  // the same cycle as the vsync rising edge.
  task automatic blanking(input bit collide);
    apply_stimulus(1'b1, collide, collide, collide, 16'hABCD);
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    if (armed)
      expect_latch();
    else
      check_output("frame_done_before_arm", 32'(fd_cnt), 32'd0);
    fd_cnt = 0;
    armed  = 1'b1;
    hit_x.delete();
    hit_y.delete();
  endtask

  task automatic send_lines(input bit rand_data, input int n_lines);
    logic ce, mk;
    logic [15:0] d;
    for (int y = 0; y < n_lines; y++) begin
      y_pos = y;
      x_pos = 0;
      while (x_pos < IMG_W) begin
        ce = ($urandom_range(0, 4) != 0);
        mk = ce ? mask_row[y][x_pos] : 1'($urandom_range(0, 1));
        d  = rand_data ? 16'($urandom) : GREEN;
        apply_stimulus(1'b0, 1'b1, ce, mk, d);
      end
      repeat (3) apply_stimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 16'($urandom));
    end
  endtask

  task automatic fill_mask(input logic [15:0] v);
    for (int y = 0; y < IMG_H; y++) mask_row[y] = v;
  endtask

  task automatic rect_mask(input int x0, input int x1, input int y0, input int y1);
    fill_mask(16'h0);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        mask_row[y][x] = 1'b1;
  endtask

  task automatic model_reset();
    armed  = 1'b0;
    mv     = 1'b0;
    fd_cnt = 0;
    hit_x.delete();
    hit_y.delete();
    exp_vs   = 1'b0;
    exp_hr   = 1'b0;
    exp_ce   = 1'b0;
    exp_data = 16'h0;
    exp_tag  = "after_reset";
  endtask

  initial begin
    model_reset();
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("power_on_reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Partial frame before the first vsync: must not be accumulated.
    fill_mask(16'hFFFF);
    send_lines(1'b1, IMG_H);
    blanking(1'b0);

    // Rectangle x 3..9, y 2..5.
    rect_mask(3, 9, 2, 5);
    send_lines(1'b1, IMG_H);
    blanking(1'b0);

    // Three isolated pixels, constant green data to expose the overlay.
    fill_mask(16'h0);
    mask_row[1][1]  = 1'b1;
    mask_row[3][12] = 1'b1;
    mask_row[6][7]  = 1'b1;
    send_lines(1'b0, IMG_H);
    blanking(1'b0);

    // Empty frame; previous box is below threshold so no overlay either.
    fill_mask(16'h0);
    send_lines(1'b0, IMG_H);
    blanking(1'b0);

    // Random frames, including a degenerate single-row box.
    for (int f = 0; f < 4; f++) begin
      for (int y = 0; y < IMG_H; y++)
        mask_row[y] = 16'($urandom) & 16'($urandom);
      send_lines(1'b1, IMG_H);
      blanking(1'b0);
    end
    rect_mask(2, 13, 4, 4);
    send_lines(1'b1, IMG_H);
    blanking(1'b0);

    // Collision of a mask pixel with the vsync rising edge.
    for (int y = 0; y < IMG_H; y++)
      mask_row[y] = 16'($urandom) & 16'($urandom) & 16'($urandom);
    send_lines(1'b1, IMG_H);
    chk_en = 1'b0;
    blanking(1'b1);

    // Reset in the middle of a frame.
    fill_mask(16'hFFFF);
    send_lines(1'b1, 2);
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_mask    = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_reset_state("midframe_reset");
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_mask    = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    chk_en = 1'b1;

    // First vsync after release only arms; the second one latches.
    blanking(1'b0);
    rect_mask(5, 10, 1, 6);
    send_lines(1'b1, IMG_H);
    blanking(1'b0);
    fill_mask(16'h0);
    send_lines(1'b0, IMG_H);
    blanking(1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
